// File: rtl/branch_resolve_ctrl_if.sv
// rtl/branch_resolve_ctrl_if.sv - prediction/resolve/update bundle between fetch, execute and the resolve controller
interface branch_resolve_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_alt_pc;
    logic            pred_ready;
    logic            res_valid;
    logic [PC_W-1:0] res_pc;
    logic            res_taken;
    logic            commit;
    logic            rollback;
    logic [PC_W-1:0] rollback_pc;
    logic            bp_update;
    logic [PC_W-1:0] bp_update_pc;
    logic            bp_result;
    logic            res_error;
    logic [CW-1:0]   count;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_alt_pc,
        output res_valid, res_pc, res_taken,
        input  pred_ready, commit, rollback, rollback_pc,
        input  bp_update, bp_update_pc, bp_result, res_error, count
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_alt_pc,
        input  res_valid, res_pc, res_taken,
        output pred_ready, commit, rollback, rollback_pc,
        output bp_update, bp_update_pc, bp_result, res_error, count
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - in-order queue of predicted branches, resolving to commit/rollback and predictor training
module branch_resolve_ctrl #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    logic [PC_W-1:0] pc_mem_q    [DEPTH];
    logic            taken_mem_q [DEPTH];
    logic [PC_W-1:0] alt_mem_q   [DEPTH];

    logic [AW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    state_t          state_q;

    logic            commit_q, rollback_q, bp_update_q, bp_result_q, res_error_q;
    logic [PC_W-1:0] rollback_pc_q, bp_update_pc_q;

    logic            pred_ready;
    logic            push;
    logic            head_hit;
    logic            correct;
    logic            mispredict;

    // Resolution only ever compares against the head: branches retire strictly in order.
    always_comb begin
        pred_ready = 1'b0;
        push       = 1'b0;
        head_hit   = 1'b0;
        correct    = 1'b0;
        mispredict = 1'b0;
        pred_ready = (state_q == ST_RUN) && (count_q < CW'(DEPTH));
        push       = bus.pred_valid && pred_ready;
        head_hit   = bus.res_valid && (state_q == ST_RUN) && (count_q != '0)
                     && (bus.res_pc == pc_mem_q[head_q]);
        correct    = head_hit && (bus.res_taken == taken_mem_q[head_q]);
        mispredict = head_hit && !correct;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            state_q        <= ST_RUN;
            commit_q       <= 1'b0;
            rollback_q     <= 1'b0;
            rollback_pc_q  <= '0;
            bp_update_q    <= 1'b0;
            bp_update_pc_q <= '0;
            bp_result_q    <= 1'b0;
            res_error_q    <= 1'b0;
        end else begin
            commit_q       <= correct;
            rollback_q     <= mispredict;
            rollback_pc_q  <= mispredict ? alt_mem_q[head_q] : '0;
            bp_update_q    <= head_hit;
            bp_update_pc_q <= head_hit ? pc_mem_q[head_q] : '0;
            bp_result_q    <= head_hit && bus.res_taken;
            res_error_q    <= bus.res_valid && !head_hit;

            case (state_q)
                ST_RUN:   state_q <= mispredict ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase

            // A mispredict also drops any same-cycle push: it lies on the wrong path.
            if (mispredict) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[tail_q]    <= bus.pred_pc;
                    taken_mem_q[tail_q] <= bus.pred_taken;
                    alt_mem_q[tail_q]   <= bus.pred_alt_pc;
                    tail_q              <= tail_q + AW'(1);
                end
                if (correct) begin
                    head_q <= head_q + AW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(correct);
            end
        end
    end

    assign bus.pred_ready   = pred_ready;
    assign bus.commit       = commit_q;
    assign bus.rollback     = rollback_q;
    assign bus.rollback_pc  = rollback_pc_q;
    assign bus.bp_update    = bp_update_q;
    assign bus.bp_update_pc = bp_update_pc_q;
    assign bus.bp_result    = bp_result_q;
    assign bus.res_error    = res_error_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    branch_resolve_ctrl_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic taken, input logic [31:0] alt);
        bus.pred_valid  = 1'b1;
        bus.pred_pc     = pc;
        bus.pred_taken  = taken;
        bus.pred_alt_pc = alt;
        tick();
        bus.pred_valid  = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken);
        bus.res_valid = 1'b1;
        bus.res_pc    = pc;
        bus.res_taken = taken;
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.pred_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.pred_ready); end
        checks++; if ({bus.commit, bus.rollback, bus.bp_update, bus.res_error, bus.bp_result} !== 5'b0)
            begin failures++; $display("FAIL reset_pulses got=%05b exp=00000", {bus.commit, bus.rollback, bus.bp_update, bus.res_error, bus.bp_result}); end
        checks++; if (bus.rollback_pc !== 32'h0 || bus.bp_update_pc !== 32'h0)
            begin failures++; $display("FAIL reset_pcs got=%0h/%0h exp=0/0", bus.rollback_pc, bus.bp_update_pc); end
    endtask

    task automatic test_commit();
        push(32'h100, 1'b1, 32'h108);
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL commit_count_push got=%0d exp=1", bus.count); end
        resolve(32'h100, 1'b1);
        checks++; if (bus.commit !== 1'b1) begin failures++; $display("FAIL commit_pulse got=%0b exp=1", bus.commit); end
        checks++; if (bus.bp_update !== 1'b1) begin failures++; $display("FAIL commit_bp_update got=%0b exp=1", bus.bp_update); end
        checks++; if (bus.bp_update_pc !== 32'h100) begin failures++; $display("FAIL commit_bp_pc got=%0h exp=100", bus.bp_update_pc); end
        checks++; if (bus.bp_result !== 1'b1) begin failures++; $display("FAIL commit_bp_result got=%0b exp=1", bus.bp_result); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL commit_count got=%0d exp=0", bus.count); end
        checks++; if (bus.rollback !== 1'b0) begin failures++; $display("FAIL commit_no_rollback got=%0b exp=0", bus.rollback); end
        tick();
        checks++; if ({bus.commit, bus.bp_update} !== 2'b00) begin failures++; $display("FAIL commit_single_pulse got=%02b exp=00", {bus.commit, bus.bp_update}); end
    endtask

    task automatic test_rollback();
        push(32'h100, 1'b1, 32'h108);
        push(32'h200, 1'b0, 32'h240);
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL rb_count_pre got=%0d exp=2", bus.count); end
        resolve(32'h100, 1'b0);
        checks++; if (bus.rollback !== 1'b1) begin failures++; $display("FAIL rb_pulse got=%0b exp=1", bus.rollback); end
        checks++; if (bus.rollback_pc !== 32'h108) begin failures++; $display("FAIL rb_pc got=%0h exp=108", bus.rollback_pc); end
        checks++; if (bus.commit !== 1'b0) begin failures++; $display("FAIL rb_no_commit got=%0b exp=0", bus.commit); end
        checks++; if (bus.bp_update !== 1'b1 || bus.bp_update_pc !== 32'h100 || bus.bp_result !== 1'b0)
            begin failures++; $display("FAIL rb_bp got=%0b/%0h/%0b exp=1/100/0", bus.bp_update, bus.bp_update_pc, bus.bp_result); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rb_count got=%0d exp=0", bus.count); end
        checks++; if (bus.pred_ready !== 1'b0) begin failures++; $display("FAIL rb_flush_ready got=%0b exp=0", bus.pred_ready); end
        tick();
        checks++; if (bus.pred_ready !== 1'b1) begin failures++; $display("FAIL rb_run_ready got=%0b exp=1", bus.pred_ready); end
        checks++; if (bus.rollback !== 1'b0 || bus.rollback_pc !== 32'h0)
            begin failures++; $display("FAIL rb_clear got=%0b/%0h exp=0/0", bus.rollback, bus.rollback_pc); end
    endtask

    task automatic test_full_order();
        for (int i = 1; i <= 4; i++) push(32'(i * 'h100), 1'b1, 32'(i * 'h100 + 8));
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        checks++; if (bus.pred_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", bus.pred_ready); end
        push(32'h999, 1'b1, 32'h9a1);
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_drop got=%0d exp=4", bus.count); end
        resolve(32'h100, 1'b1);
        checks++; if (bus.commit !== 1'b1 || bus.count !== 3'd3)
            begin failures++; $display("FAIL full_pop got=%0b/%0d exp=1/3", bus.commit, bus.count); end
        checks++; if (bus.pred_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%0b exp=1", bus.pred_ready); end
        push(32'h500, 1'b1, 32'h508);
        for (int i = 2; i <= 5; i++) begin
            resolve(32'(i * 'h100), 1'b1);
            checks++; if (bus.commit !== 1'b1 || bus.bp_update_pc !== 32'(i * 'h100))
                begin failures++; $display("FAIL order_%0d got=%0b/%0h exp=1/%0h", i, bus.commit, bus.bp_update_pc, i * 'h100); end
        end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL order_empty got=%0d exp=0", bus.count); end
    endtask

    task automatic test_error();
        push(32'h100, 1'b1, 32'h108);
        resolve(32'h300, 1'b1);
        checks++; if (bus.res_error !== 1'b1) begin failures++; $display("FAIL err_mismatch got=%0b exp=1", bus.res_error); end
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL err_count got=%0d exp=1", bus.count); end
        checks++; if ({bus.bp_update, bus.commit, bus.rollback} !== 3'b000)
            begin failures++; $display("FAIL err_no_pulse got=%03b exp=000", {bus.bp_update, bus.commit, bus.rollback}); end
        resolve(32'h100, 1'b1);
        checks++; if (bus.commit !== 1'b1 || bus.res_error !== 1'b0)
            begin failures++; $display("FAIL err_recover got=%0b/%0b exp=1/0", bus.commit, bus.res_error); end
        resolve(32'h100, 1'b1);
        checks++; if (bus.res_error !== 1'b1 || bus.bp_update !== 1'b0)
            begin failures++; $display("FAIL err_empty got=%0b/%0b exp=1/0", bus.res_error, bus.bp_update); end
    endtask

    task automatic test_same_cycle();
        push(32'h100, 1'b1, 32'h108);
        bus.pred_valid = 1'b1; bus.pred_pc = 32'h400; bus.pred_taken = 1'b1; bus.pred_alt_pc = 32'h408;
        resolve(32'h100, 1'b1);
        bus.pred_valid = 1'b0;
        checks++; if (bus.commit !== 1'b1 || bus.count !== 3'd1)
            begin failures++; $display("FAIL same_commit got=%0b/%0d exp=1/1", bus.commit, bus.count); end
        bus.pred_valid = 1'b1; bus.pred_pc = 32'h500; bus.pred_taken = 1'b1; bus.pred_alt_pc = 32'h508;
        resolve(32'h400, 1'b0);
        bus.pred_valid = 1'b0;
        checks++; if (bus.rollback !== 1'b1 || bus.rollback_pc !== 32'h408)
            begin failures++; $display("FAIL same_rb got=%0b/%0h exp=1/408", bus.rollback, bus.rollback_pc); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL same_rb_count got=%0d exp=0", bus.count); end
        tick();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL same_discard got=%0d exp=0", bus.count); end
        resolve(32'h500, 1'b1);
        checks++; if (bus.res_error !== 1'b1) begin failures++; $display("FAIL same_discard_err got=%0b exp=1", bus.res_error); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            push(32'h1000 + 32'(i * 4), i[0], 32'h2000 + 32'(i * 4));
            resolve(32'h1000 + 32'(i * 4), i[0]);
            checks++; if (bus.commit !== 1'b1 || bus.bp_update_pc !== 32'h1000 + 32'(i * 4) || bus.bp_result !== i[0])
                begin failures++; $display("FAIL wrap_%0d got=%0b/%0h/%0b exp=1/%0h/%0b", i, bus.commit, bus.bp_update_pc, bus.bp_result, 32'h1000 + i * 4, i[0]); end
        end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(32'h700 + 32'(i * 4), 1'b1, 32'h800);
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL rstmid_pre got=%0d exp=3", bus.count); end
        rst = 1'b1;
        bus.res_valid = 1'b1; bus.res_pc = 32'h700; bus.res_taken = 1'b0;
        tick();
        rst = 1'b0;
        bus.res_valid = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.pred_ready !== 1'b1)
            begin failures++; $display("FAIL rstmid_state got=%0d/%0b exp=0/1", bus.count, bus.pred_ready); end
        checks++; if ({bus.commit, bus.rollback, bus.bp_update, bus.res_error} !== 4'b0)
            begin failures++; $display("FAIL rstmid_pulse0 got=%04b exp=0000", {bus.commit, bus.rollback, bus.bp_update, bus.res_error}); end
        tick();
        checks++; if ({bus.commit, bus.rollback, bus.bp_update, bus.res_error} !== 4'b0)
            begin failures++; $display("FAIL rstmid_pulse1 got=%04b exp=0000", {bus.commit, bus.rollback, bus.bp_update, bus.res_error}); end
        resolve(32'h700, 1'b1);
        checks++; if (bus.res_error !== 1'b1) begin failures++; $display("FAIL rstmid_flushed got=%0b exp=1", bus.res_error); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.pred_valid  = 1'b0;
        bus.pred_pc     = '0;
        bus.pred_taken  = 1'b0;
        bus.pred_alt_pc = '0;
        bus.res_valid   = 1'b0;
        bus.res_pc      = '0;
        bus.res_taken   = 1'b0;
        test_reset();
        test_commit();
        test_rollback();
        test_full_order();
        test_error();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencing controller for the branch predictor. It keeps an in-order queue of outstanding predicted branches. When the execute stage resolves a branch, the block pulses commit or rollback toward fetch. It also drives the predictor's update port, one pulse per resolved branch.

Parameters:
DEPTH, 4, maximum number of outstanding predicted branches (power of 2, at least 2)
PC_W, 32, PC width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pred_valid  in  1  fetch has issued a prediction this cycle
pred_pc  in  PC_W  PC of the predicted branch
pred_taken  in  1  direction that was predicted
pred_alt_pc  in  PC_W  path not chosen: notTakenPC if predicted taken, else takenPC
pred_ready  out  1  an entry can be accepted this cycle
res_valid  in  1  execute has resolved a branch this cycle
res_pc  in  PC_W  PC of the resolved branch
res_taken  in  1  actual direction
commit  out  1  one-cycle pulse: head prediction was correct
rollback  out  1  one-cycle pulse: head prediction was wrong
rollback_pc  out  PC_W  fetch target; valid while rollback=1, otherwise 0
bp_update  out  1  one-cycle pulse to the predictor update input
bp_update_pc  out  PC_W  PC to train
bp_result  out  1  actual direction to train with
res_error  out  1  one-cycle pulse: resolve did not match the head, or queue was empty
count  out  log2(DEPTH)+1  number of occupied entries

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- On reset: queue empty, count=0, state=RUN, and all outputs 0 except pred_ready=1.
- Storage: circular FIFO of DEPTH entries, each {pc, taken, alt_pc}. Head and tail pointers wrap modulo DEPTH.
- Entry is accepted when pred_valid && pred_ready at a clock edge. It is written at tail and tail increments.
- pred_ready is combinational: (state==RUN) && (count<DEPTH).
  - A resolve in the same cycle does not free a slot for that cycle's predict.
  - pred_valid while pred_ready=0 is dropped; fetch must hold the request.
- A resolve matches when res_valid && count!=0 && res_pc==head.pc. Resolution is strictly in order; there is no CAM search.
- On a matched resolve, outputs are registered and appear the cycle after res_valid (1-cycle latency):
  - bp_update=1, bp_update_pc=head.pc, bp_result=res_taken.
  - If res_taken==head.taken: commit=1; head is popped.
  - Otherwise: rollback=1, rollback_pc=head.alt_pc; the whole queue is flushed (count→0) and state goes to FLUSH.
- Unmatched resolve (res_valid with empty queue or PC mismatch): res_error=1 the next cycle. No queue change, no bp_update.
- State machine:
  - RUN: normal operation.
  - RUN → FLUSH on a mispredict.
  - FLUSH lasts exactly 1 cycle, with pred_ready=0 while fetch redirects, then FLUSH → RUN unconditionally.
  - res_valid during FLUSH is treated as unmatched, because the queue is empty.
- Predict and resolve in the same cycle:
  - If the resolve commits, the push and pop both happen and count is unchanged.
  - If the resolve mispredicts, the new prediction is also discarded, since it lies on the wrong path.
- commit, rollback and bp_update are never asserted in two consecutive cycles unless two resolves arrive back-to-back. Each resolve produces exactly one pulse.
- Pointer wrap: after DEPTH pushes and DEPTH pops, head==tail and count=0. Full versus empty is taken from count, never from pointer equality.
- Reset mid-operation: all entries are discarded and no pulse is emitted in the reset cycle or the following cycle.

Test Plan:
- Reset, then push {pc=0x100, taken=1, alt=0x108}; resolve 0x100 taken=1. Next cycle: commit=1, bp_update=1, bp_update_pc=0x100, bp_result=1, count=0.
- Push 0x100 (taken=1, alt=0x108) and 0x200 (taken=0, alt=0x240); resolve 0x100 taken=0. Next cycle: rollback=1, rollback_pc=0x108, count=0, pred_ready=0 for 1 cycle, then pred_ready=1.
- Push 4 entries; count=4 and pred_ready=0. A 5th pred_valid is dropped. Commit one entry, then pred_ready=1. Push 0x500 and check it resolves after the other three (order check).
- Resolve 0x300 while the head is 0x100: res_error=1, count unchanged, no bp_update. Resolve with an empty queue: res_error=1.
- Same cycle: push 0x400 and resolve head 0x100 correct. Next cycle: commit=1, count unchanged. Repeat with a mispredicted resolve: 0x400 is discarded and count=0.
- Run 10 push/commit pairs to wrap the pointers twice: every commit carries the matching PC. Assert rst with 3 entries queued: count=0, no pulses.
